// File: rtl/conv_weight_loader.sv
// Weight BRAM sequencer for the 3x3x3 conv datapath.
// WRITE streams N_W words into a dual-port BRAM; LOAD reads them back on
// both ports in parallel and packs them into a flat weight vector.
//
// Ports:
//   clk, RESET           clock, async active-high reset
//   start_wr, start_rd   op requests, sampled in IDLE (write wins)
//   in_valid, in_data    upstream weight stream; wr_ready accepts
//   wren_*, rden_*       BRAM enables, ports a/b
//   addr_*, data_*       BRAM address / write data; q_* read data
//   weights              packed result, weight 0 in the MSBs
//   weights_valid        weights holds a complete LOAD result
//   busy, done           not-idle flag, one-cycle end-of-op pulse
module conv_weight_loader #(
  parameter int DW     = 16,
  parameter int N_W    = 27,
  parameter int AW     = 5,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start_wr,
  input  logic              start_rd,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              wr_ready,
  output logic              wren_a,
  output logic              wren_b,
  output logic              rden_a,
  output logic              rden_b,
  output logic [AW-1:0]     addr_a,
  output logic [AW-1:0]     addr_b,
  output logic [DW-1:0]     data_a,
  output logic [DW-1:0]     data_b,
  input  logic [DW-1:0]     q_a,
  input  logic [DW-1:0]     q_b,
  output logic [DW*N_W-1:0] weights,
  output logic              weights_valid,
  output logic              busy,
  output logic              done
);

  localparam int HA = (N_W + 1) / 2;
  localparam int HB = N_W - HA;

  localparam logic [AW-1:0] A_NONE   = '1;
  localparam logic [AW-1:0] A_HA     = AW'(HA);
  localparam logic [AW-1:0] A_HB     = AW'(HB);
  localparam logic [AW-1:0] A_LAST_W = AW'(N_W - 1);
  localparam logic [AW-1:0] A_LAST_R = AW'(HA - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  state_t          state;
  logic [AW-1:0]   wr_cnt;
  logic [AW-1:0]   rd_cnt;
  logic [DW-1:0]   wt [N_W];

  // Read tag pipeline: entry 0 is loaded at the edge the BRAM samples the
  // port-A address, so the last entry lines up with q on the capture edge.
  logic [RD_LAT-1:0] tag_vld;
  logic [AW-1:0]     tag_idx [RD_LAT];

  logic          cap_vld;
  logic [AW-1:0] cap_idx;

  assign cap_vld = tag_vld[RD_LAT-1];
  assign cap_idx = tag_idx[RD_LAT-1];

  for (genvar k = 0; k < N_W; k++) begin : g_pack
    assign weights[DW*(N_W-k)-1 -: DW] = wt[k];
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      wr_ready      <= 1'b0;
      wren_a        <= 1'b0;
      wren_b        <= 1'b0;
      rden_a        <= 1'b0;
      rden_b        <= 1'b0;
      addr_a        <= A_NONE;
      addr_b        <= A_NONE;
      data_a        <= '0;
      data_b        <= '0;
      weights_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tag_vld       <= '0;
      for (int k = 0; k < RD_LAT; k++) tag_idx[k] <= '0;
      for (int k = 0; k < N_W; k++) wt[k] <= '0;
    end else begin
      done <= 1'b0;

      tag_vld[0] <= rden_a;
      tag_idx[0] <= addr_a;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end

      // Slots are filled in place; port B only carried data for low indices.
      if (cap_vld) begin
        wt[cap_idx] <= q_a;
        if (cap_idx < A_HB) wt[A_HA + cap_idx] <= q_b;
      end

      unique case (state)
        IDLE: begin
          wren_a <= 1'b0;
          wren_b <= 1'b0;
          rden_a <= 1'b0;
          rden_b <= 1'b0;
          addr_a <= A_NONE;
          addr_b <= A_NONE;
          if (start_wr) begin
            state         <= WR;
            wr_cnt        <= '0;
            wr_ready      <= 1'b1;
            weights_valid <= 1'b0;
            busy          <= 1'b1;
          end else if (start_rd) begin
            state  <= RD;
            busy   <= 1'b1;
            rden_a <= 1'b1;
            addr_a <= '0;
            rden_b <= (HB > 0);
            addr_b <= (HB > 0) ? A_HA : A_NONE;
            rd_cnt <= AW'(1);
          end
        end

        WR: begin
          wren_a <= 1'b0;
          wren_b <= 1'b0;
          addr_a <= A_NONE;
          addr_b <= A_NONE;
          if (wr_ready && in_valid) begin
            if (wr_cnt < A_HA) begin
              wren_a <= 1'b1;
              addr_a <= wr_cnt;
              data_a <= in_data;
            end else begin
              wren_b <= 1'b1;
              addr_b <= wr_cnt;
              data_b <= in_data;
            end
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == A_LAST_W) wr_ready <= 1'b0;
          end else if (!wr_ready) begin
            // Last write has been presented; wrap up.
            state  <= IDLE;
            wr_cnt <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end

        RD: begin
          if (rd_cnt < A_HA) begin
            rden_a <= 1'b1;
            addr_a <= rd_cnt;
            if (rd_cnt < A_HB) begin
              rden_b <= 1'b1;
              addr_b <= A_HA + rd_cnt;
            end else begin
              rden_b <= 1'b0;
              addr_b <= A_NONE;
            end
            rd_cnt <= rd_cnt + 1'b1;
          end else begin
            rden_a <= 1'b0;
            rden_b <= 1'b0;
            addr_a <= A_NONE;
            addr_b <= A_NONE;
          end
          if (cap_vld && cap_idx == A_LAST_R) begin
            state         <= IDLE;
            rd_cnt        <= '0;
            busy          <= 1'b0;
            done          <= 1'b1;
            weights_valid <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_weight_loader.sv
// Self-checking bench for conv_weight_loader.
// Drives write/load ops against a BRAM model; a second RD_LAT=1 instance
// shares the stimulus to check the shorter load latency.
module tb_conv_weight_loader;

  localparam int DW  = 16;
  localparam int N_W = 27;
  localparam int AW  = 5;
  localparam int HA  = 14;

  logic              clk;
  logic              RESET;
  logic              start_wr;
  logic              start_rd;
  logic              in_valid;
  logic [DW-1:0]     in_data;

  logic              wr_ready, wren_a, wren_b, rden_a, rden_b;
  logic [AW-1:0]     addr_a, addr_b;
  logic [DW-1:0]     data_a, data_b, q_a, q_b;
  logic [DW*N_W-1:0] weights;
  logic              weights_valid, busy, done;

  logic              wr_ready1, wren_a1, wren_b1, rden_a1, rden_b1;
  logic [AW-1:0]     addr_a1, addr_b1;
  logic [DW-1:0]     data_a1, data_b1, q_a1, q_b1;
  logic [DW*N_W-1:0] weights1;
  logic              weights_valid1, busy1, done1;

  conv_weight_loader #(.DW(DW), .N_W(N_W), .AW(AW), .RD_LAT(2)) dut (
    .clk(clk), .RESET(RESET),
    .start_wr(start_wr), .start_rd(start_rd),
    .in_valid(in_valid), .in_data(in_data), .wr_ready(wr_ready),
    .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .q_a(q_a), .q_b(q_b), .weights(weights),
    .weights_valid(weights_valid), .busy(busy), .done(done)
  );

  conv_weight_loader #(.DW(DW), .N_W(N_W), .AW(AW), .RD_LAT(1)) dut1 (
    .clk(clk), .RESET(RESET),
    .start_wr(start_wr), .start_rd(start_rd),
    .in_valid(in_valid), .in_data(in_data), .wr_ready(wr_ready1),
    .wren_a(wren_a1), .wren_b(wren_b1), .rden_a(rden_a1), .rden_b(rden_b1),
    .addr_a(addr_a1), .addr_b(addr_b1), .data_a(data_a1), .data_b(data_b1),
    .q_a(q_a1), .q_b(q_b1), .weights(weights1),
    .weights_valid(weights_valid1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: written by dut, read by both instances.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] pa [2];
  logic [DW-1:0] pb [2];
  logic [DW-1:0] pa1, pb1;

  initial for (int k = 0; k < 32; k++) mem[k] = '0;

  always @(posedge clk) begin
    if (wren_a) mem[addr_a] <= data_a;
    if (wren_b) mem[addr_b] <= data_b;
    pa[0] <= mem[addr_a];
    pa[1] <= pa[0];
    pb[0] <= mem[addr_b];
    pb[1] <= pb[0];
    pa1   <= mem[addr_a1];
    pb1   <= mem[addr_b1];
  end

  assign q_a  = pa[1];
  assign q_b  = pb[1];
  assign q_a1 = pa1;
  assign q_b1 = pb1;

  typedef struct packed {
    logic          pb;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t               wq [$];
  wr_t               e;
  logic [DW*N_W-1:0] rq [$];
  int                mem_exp [N_W];
  int                checks;
  int                failures;
  int                nwr;
  logic              prev_done;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (RESET) begin
      chk("rst_no_done", {31'd0, done}, 0);
    end else begin
      if (wren_a || wren_b) begin
        chk("wr_one_port", {31'd0, wren_a && wren_b}, 0);
        if (wq.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          e = wq.pop_front();
          chk("wr_port", {31'd0, wren_b}, {31'd0, e.pb});
          chk("wr_addr", {27'd0, wren_b ? addr_b : addr_a}, {27'd0, e.addr});
          chk("wr_data", {16'd0, wren_b ? data_b : data_a}, {16'd0, e.data});
          nwr++;
        end
      end
      if (rden_a) chk("rda_range", {31'd0, addr_a <= 5'd26}, 1);
      if (rden_b) chk("rdb_range", {31'd0, addr_b <= 5'd26}, 1);
      if (done) chk("done_pulse", {31'd0, prev_done}, 0);
    end
    prev_done = done;
  end

  task automatic do_write(input int base, input bit gaps, input bit both,
                          input bit rd_noise);
    int n, cyc, k;
    nwr = 0;
    @(posedge clk); #1;
    start_wr = 1'b1;
    start_rd = both;
    @(posedge clk); #1;
    start_wr = 1'b0;
    start_rd = rd_noise;
    chk("wr_entry_ready", {31'd0, wr_ready}, 1);
    chk("wr_entry_busy", {31'd0, busy}, 1);
    chk("wr_entry_wv", {31'd0, weights_valid}, 0);
    chk("wr_entry_rden", {31'd0, rden_a}, 0);
    n = 0;
    cyc = 0;
    while (n < N_W && cyc < 200) begin
      in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      in_data  = DW'(base + n);
      if (in_valid && wr_ready) begin
        wq.push_back('{pb: (n >= HA), addr: AW'(n), data: DW'(base + n)});
        mem_exp[n] = base + n;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_rd = 1'b0;
    chk("wr_beats", n, N_W);
    chk("wr_ready_low", {31'd0, wr_ready}, 0);
    k = 0;
    while (!done && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wr_done", {31'd0, done}, 1);
    chk("wr_done_lat", k, 1);
    chk("wr_done_busy", {31'd0, busy}, 0);
    chk("wr_done_addr", {27'd0, addr_a}, 31);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("wr_idle_busy", {31'd0, busy}, 0);
    chk("wr_idle_rden", {31'd0, rden_a}, 0);
    chk("wr_count", nwr, N_W);
    chk("wr_queue_empty", wq.size(), 0);
  endtask

  task automatic do_load(input bit wv_hold);
    int t0, t1;
    logic [DW*N_W-1:0] v;
    logic [DW*N_W-1:0] x;
    @(posedge clk); #1;
    start_rd = 1'b1;
    for (int k = 0; k < N_W; k++) v[DW*(N_W-k)-1 -: DW] = DW'(mem_exp[k]);
    rq.push_back(v);
    @(posedge clk); #1;
    start_rd = 1'b0;
    chk("ld_busy", {31'd0, busy}, 1);
    chk("ld_rden0", {31'd0, rden_a}, 1);
    chk("ld_addra0", {27'd0, addr_a}, 0);
    chk("ld_addrb0", {27'd0, addr_b}, HA);
    chk("ld_wv_hold", {31'd0, weights_valid}, {31'd0, wv_hold});
    t0 = 0;
    t1 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done && t0 == 0) begin
        t0 = k;
        chk("ld_wv_at_done", {31'd0, weights_valid}, 1);
      end
      if (done1 && t1 == 0) t1 = k;
      if (t0 != 0 && t1 != 0) break;
    end
    chk("ld_lat", t0, HA + 2);
    chk("ld_lat_rdlat1", t1, HA + 1);
    chk("ld_wv1", {31'd0, weights_valid1}, 1);
    if (rq.size() == 0) begin
      chk("ld_queue", 0, 1);
    end else begin
      x = rq.pop_front();
      for (int k = 0; k < N_W; k++) begin
        chk($sformatf("ld_w%0d", k), {16'd0, weights[DW*(N_W-k)-1 -: DW]},
            {16'd0, x[DW*(N_W-k)-1 -: DW]});
        chk($sformatf("ld1_w%0d", k), {16'd0, weights1[DW*(N_W-k)-1 -: DW]},
            {16'd0, x[DW*(N_W-k)-1 -: DW]});
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    nwr       = 0;
    prev_done = 1'b0;
    for (int k = 0; k < N_W; k++) mem_exp[k] = 0;
    RESET    = 1'b1;
    start_wr = 1'b0;
    start_rd = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_a", {27'd0, addr_a}, 31);
    chk("rst_addr_b", {27'd0, addr_b}, 31);
    chk("rst_wren", {30'd0, wren_a, wren_b}, 0);
    chk("rst_rden", {30'd0, rden_a, rden_b}, 0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wv", {31'd0, weights_valid}, 0);
    chk("rst_data", {data_a, data_b}, 0);
    chk("rst_w0", {16'd0, weights[DW*N_W-1 -: DW]}, 0);
    RESET = 1'b0;

    do_write(100, 1'b0, 1'b0, 1'b0);
    do_load(1'b0);
    do_load(1'b1);
    do_write(200, 1'b1, 1'b1, 1'b1);
    do_load(1'b0);

    // Abort a load mid-flight with an asynchronous reset.
    @(posedge clk); #1;
    start_rd = 1'b1;
    @(posedge clk); #1;
    start_rd = 1'b0;
    repeat (5) @(posedge clk);
    #2 RESET = 1'b1;
    #1;
    chk("arst_addr_a", {27'd0, addr_a}, 31);
    chk("arst_addr_b", {27'd0, addr_b}, 31);
    chk("arst_rden", {30'd0, rden_a, rden_b}, 0);
    chk("arst_wv", {31'd0, weights_valid}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_busy1", {31'd0, busy1}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_w0", {16'd0, weights[DW*N_W-1 -: DW]}, 0);
    chk("arst_w26", {16'd0, weights[DW-1:0]}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    RESET = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_busy", {31'd0, busy}, 0);
      chk("post_rst_done", {31'd0, done}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_weight_loader.md
Name: conv_weight_loader

Overview:
- Sequences the dual-port weight BRAM that feeds the 3x3x3 convolution datapath.
- WRITE op: accepts N_W weight words from an upstream valid/ready stream and writes them to BRAM addresses 0..N_W-1.
- LOAD op: reads all N_W words using both BRAM ports in parallel, assembles them into a flat weight vector for the cnn/paral_add array, and asserts weights_valid.

Parameters:
- DW, 16, weight word width.
- N_W, 27, number of weights (3 channels x 9 taps).
- AW, 5, BRAM address width; requires 2^AW > N_W.
- RD_LAT, 2, BRAM read latency in cycles, counted from the cycle addr/rden are presented to the cycle q is valid; RD_LAT >= 1.
- Derived: HA = ceil(N_W/2) = 14 (port A handles indices 0..HA-1); HB = N_W-HA = 13 (port B handles indices HA..N_W-1).

Ports:
- clk  in  1  clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- start_wr  in  1  request WRITE op (level sampled in IDLE).
- start_rd  in  1  request LOAD op (level sampled in IDLE).
- in_valid  in  1  upstream weight word valid.
- in_data  in  DW  upstream weight word.
- wr_ready  out  1  accepting in_data.
- wren_a, wren_b  out  1  BRAM write enables.
- rden_a, rden_b  out  1  BRAM read enables.
- addr_a, addr_b  out  AW  BRAM addresses.
- data_a, data_b  out  DW  BRAM write data.
- q_a, q_b  in  DW  BRAM read data.
- weights  out  DW*N_W  weight k at bits [DW*(N_W-k)-1 -: DW]; weight 0 in the MSBs.
- weights_valid  out  1  weights holds a complete LOAD result.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of either op.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; addr_a/addr_b all ones; wren/rden 0; data 0; wr_ready 0; weights 0; weights_valid 0; busy 0; done 0; all counters 0.
- RESET asserted mid-operation aborts immediately to the reset values; no partial done pulse.
- States: IDLE, WR, RD.
- IDLE:
  - start_wr has priority over start_rd when both are high.
  - On start_wr: go to WR, clear weights_valid, set wr_ready=1 at the same edge.
  - On start_rd: go to RD and present index 0 at the same edge.
  - Starts seen outside IDLE are ignored.
- WR:
  - Each cycle with in_valid&&wr_ready is a beat for index i = wr_cnt.
  - i<HA: drive wren_a=1, addr_a=i, data_a=in_data at the next edge.
  - Otherwise: drive wren_b=1, addr_b=i, data_b=in_data.
  - Address of weight k is k on either port. Only one port writes per cycle.
  - Non-beat cycles: wren 0, addr all ones.
  - After beat N_W-1: wr_ready drops at the same edge; the last write is presented the next cycle. The following edge returns to IDLE with done=1 for one cycle and addresses all ones.
  - in_valid is ignored when wr_ready=0.
- RD:
  - Issue index i = 0..HA-1, one per cycle, with no stalls.
  - Port A: rden_a=1, addr_a=i.
  - Port B, for i<HB: rden_b=1, addr_b=HA+i. For i=HA-1 (beyond HB): rden_b=0, addr_b all ones.
  - An RD_LAT-deep tag pipeline carries (valid, i).
  - Data for index i is captured at edge i+RD_LAT+1 relative to the start edge (edge 0). q_a goes to slot i; q_b goes to slot HA+i when port B was enabled.
  - Slots are written in place, not shifted. Untouched slots keep their prior value.
  - After the final issue: rden 0, addresses all ones.
  - At edge HA+RD_LAT (16 with defaults), the last capture occurs and, at the same edge, weights_valid=1, done=1, state=IDLE.
- weights_valid stays high until the next start_wr or RESET. Another LOAD leaves it high and overwrites slots in place.
- BRAM contents are not checked; no address ever exceeds N_W-1 while an enable is high.

Test Plan:
- Reset check: assert RESET mid-RD at cycle 5 -> all outputs take reset values asynchronously (addr=31, weights_valid=0, busy=0), with no done pulse.
- WRITE: pulse start_wr, stream values 100..126 with in_valid continuous -> wren_a on addrs 0..13 with data 100..113, then wren_b on addrs 14..26 with data 114..126, then done, and wr_ready low after 27 beats.
- WRITE backpressure: in_valid toggled 1,0,1,0 -> exactly 27 writes, with no addr/data change on idle cycles.
- LOAD with the BRAM model holding k+100: start_rd -> done and weights_valid rise exactly 16 cycles after the start edge; weight 0=100 in the MSBs, weight 26=126 in the LSBs; rden_b is never high with addr_b>26.
- Simultaneous start_wr=start_rd=1 in IDLE -> WR is entered, weights_valid cleared; start_rd pulsed during WR has no effect.
- RD_LAT=1 build: LOAD done at cycle 15 with the same packed vector.
